divider_iter_param: RTL and testbench
=====================================

DIVIDER_ITER_PARAM -- requirements
Module: divider_iter_param

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; the block SHALL support any WIDTH >= 2.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low (asserted when 0).
REQ-004 signed_i  input  1  1 = two's-complement divide, 0 = unsigned; sampled only with an accepted start.
REQ-005 opdata1_i  input  WIDTH  dividend; sampled only with an accepted start.
REQ-006 opdata2_i  input  WIDTH  divisor; sampled only with an accepted start.
REQ-007 start_i  input  1  1 = request a division, 0 = release the result.
REQ-008 annul_i  input  1  1 = cancel an accepted or in-flight division.
REQ-009 result_o  output  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}.
REQ-010 ready_o  output  1  1 = result_o is valid.
REQ-011 busy_o  output  1  1 whenever the state is not FREE.
REQ-012 div_zero_o  output  1  1 = the current result came from a zero divisor; valid while ready_o = 1.

Function
REQ-013 The FSM SHALL have four states, FREE, BYZERO, ON and END, and SHALL use an iteration counter of clog2(WIDTH+1) bits.
REQ-014 In FREE, start_i=1 with annul_i=0 is accepted at edge E0: it latches the operands and signed_i, computes their magnitudes, and goes to BYZERO if opdata2_i=0, otherwise to ON with the counter cleared.
REQ-015 In FREE without an accepted start, ready_o, div_zero_o and result_o SHALL be held at 0.
REQ-016 ON performs one restoring shift-subtract step per cycle on magnitudes with a WIDTH+1-bit trial subtract; a non-negative trial shifts in quotient bit 1, a negative trial shifts in 0.
REQ-017 After WIDTH steps (edges E1..E_WIDTH), edge E_WIDTH+1 applies sign fix-up and moves to END; the counter then clears.
REQ-018 Sign fix-up applies only when the latched signed_i=1: the quotient is negated if the operand signs differ, and the remainder is negated if the dividend is negative.
REQ-019 Edge E_WIDTH+2 (the first edge in END) SHALL load result_o and set ready_o=1, giving a latency of WIDTH+2 edges from acceptance to ready.
REQ-020 END SHALL hold ready_o and result_o until start_i=0 is sampled; that edge returns to FREE and clears ready_o, result_o and div_zero_o.
REQ-021 A start_i that stays 1 throughout END SHALL NOT begin a new division; a new start is accepted only from FREE.
REQ-022 BYZERO SHALL move to END at E1 with the remainder and quotient zero and div_zero_o=1; ready_o rises at E2.
REQ-023 annul_i=1 while in ON SHALL force FREE at the next edge; ready_o never rises for that division.
REQ-024 annul_i SHALL be ignored in BYZERO and END.
REQ-025 Signed most-negative / -1 SHALL produce quotient = most-negative value (natural wrap) and remainder 0, with no flag.
REQ-026 Signed results SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-027 Operand inputs SHALL NOT affect an in-flight division.

Reset
REQ-028 While rst=0, the block SHALL asynchronously force state FREE, counter 0, ready_o=0, busy_o=0, div_zero_o=0 and result_o=0; internal datapath registers may hold any value.
REQ-029 Reset asserted in any state, including mid-ON, SHALL abort the operation; after release, the first accepted start SHALL behave exactly as from power-up.

Configuration
REQ-030 Macro DIV_EARLY_OUT_EN, when defined: if the divisor is nonzero and |dividend| < |divisor| (unsigned compare of the magnitudes), E0 SHALL go directly to END with quotient 0 and remainder = opdata1_i, and ready_o rises at E1.
REQ-031 When DIV_EARLY_OUT_EN is undefined, every nonzero-divisor division SHALL take the full WIDTH+2 latency; results SHALL be bit-identical in both builds.

Verification (WIDTH=32)
REQ-032 Unsigned 100/7 -> quotient 0x0000000E, remainder 0x00000002, ready_o rises at E34, busy_o=1 from E0 until return to FREE.
REQ-033 Signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-034 Divisor 0 -> div_zero_o=1, result_o=0, ready_o at E2; dropping start_i returns to FREE with all outputs 0.
REQ-035 annul_i=1 at E5 of an ON division -> FREE at E6, ready_o never rises; a following 9/3 -> quotient 3, remainder 0 at the normal latency.
REQ-036 Unsigned 3/10 -> quotient 0, remainder 3, ready_o at E1 with DIV_EARLY_OUT_EN and at E34 without; rst pulsed low mid-ON -> outputs 0 immediately, and the next division is correct.

Source files
------------

// File: rtl/divider_iter_param.sv
// ---------------------------------------------------------------------------
// divider_iter_param
//
// Purpose:
//   Iterative restoring divider for WIDTH-bit operands. It handles signed
//   (two's-complement) and unsigned division and retires one quotient bit per
//   clock. Signed operands are divided as magnitudes, and the signs are
//   restored in a fix-up cycle at the end. A zero divisor skips the iteration
//   and reports a zero result with div_zero_o set.
//
//   Timing from the accepting edge E0:
//     normal     : WIDTH steps, one fix-up edge, then ready at E(WIDTH+2)
//     zero div   : ready at E2
//     early out  : ready at E1 (only when DIV_EARLY_OUT_EN is defined)
//
// Configuration:
//   DIV_EARLY_OUT_EN - when defined, a division with a nonzero divisor and
//                      |dividend| < |divisor| completes immediately. The
//                      result is quotient 0 and remainder = dividend. Results
//                      are bit-identical with or without the macro; only the
//                      latency changes.
//
// Ports:
//   clk         in   sole clock, rising edge
//   rst         in   asynchronous reset, active low
//   signed_i    in   1 = signed divide, 0 = unsigned (sampled on accept)
//   opdata1_i   in   dividend (sampled on accept)
//   opdata2_i   in   divisor  (sampled on accept)
//   start_i     in   1 = request a division, 0 = release the held result
//   annul_i     in   1 = cancel an accepted or iterating division
//   result_o    out  {remainder, quotient}
//   ready_o     out  result_o is valid
//   busy_o      out  FSM is not idle
//   div_zero_o  out  current result came from a zero divisor
// ---------------------------------------------------------------------------
module divider_iter_param #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 div_zero_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  // quot_q starts as the dividend magnitude. Each step shifts out its top
  // bit into the partial remainder and shifts a quotient bit into the bottom.
  logic [WIDTH-1:0]     quot_q;
  logic [WIDTH-1:0]     rem_q;
  logic [WIDTH-1:0]     divisor_q;
  logic                 negQuot_q;
  logic                 negRem_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 ready_q;
  logic                 divZero_q;

  logic [WIDTH-1:0]     mag1;
  logic [WIDTH-1:0]     mag2;
  logic                 earlyOut;
  logic [WIDTH:0]       shifted;
  logic [WIDTH:0]       trial;
  logic [WIDTH-1:0]     remStep_d;
  logic [WIDTH-1:0]     quotStep_d;
  logic [WIDTH-1:0]     remFix_d;
  logic [WIDTH-1:0]     quotFix_d;

  // The operand magnitudes are used only on the accepting edge.
  // Negating the most-negative value wraps back to itself. Read as
  // unsigned, that is the correct magnitude 2^(WIDTH-1).
  always_comb begin
    mag1 = (signed_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    mag2 = (signed_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
  end

`ifdef DIV_EARLY_OUT_EN
  // A dividend magnitude below the divisor magnitude gives quotient 0.
  // The remainder is then the dividend itself, with its original sign.
  assign earlyOut = (mag1 < mag2);
`else
  assign earlyOut = 1'b0;
`endif

  // One restoring step. The partial remainder is always below the divisor,
  // so the shifted value fits in WIDTH+1 bits. The top bit of the trial
  // difference is therefore an exact "went negative" flag.
  always_comb begin
    shifted = {rem_q, quot_q[WIDTH-1]};
    trial   = shifted - {1'b0, divisor_q};
    if (!trial[WIDTH]) begin
      remStep_d  = trial[WIDTH-1:0];
      quotStep_d = {quot_q[WIDTH-2:0], 1'b1};
    end else begin
      remStep_d  = shifted[WIDTH-1:0];
      quotStep_d = {quot_q[WIDTH-2:0], 1'b0};
    end
  end

  // Sign fix-up. The negate flags are zero for unsigned divisions.
  always_comb begin
    quotFix_d = negQuot_q ? (~quot_q + 1'b1) : quot_q;
    remFix_d  = negRem_q  ? (~rem_q  + 1'b1) : rem_q;
  end

  // Control FSM and datapath registers.
  // END is entered with the final quotient and remainder already in
  // quot_q/rem_q. The first END edge copies them to result_o.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FREE;
      cnt_q     <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      negQuot_q <= 1'b0;
      negRem_q  <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
      divZero_q <= 1'b0;
    end else begin
      case (state_q)
        FREE: begin
          ready_q   <= 1'b0;
          divZero_q <= 1'b0;
          result_q  <= '0;
          cnt_q     <= '0;
          if (start_i && !annul_i) begin
            negQuot_q <= signed_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            negRem_q  <= signed_i && opdata1_i[WIDTH-1];
            divisor_q <= mag2;
            quot_q    <= mag1;
            rem_q     <= '0;
            if (opdata2_i == '0) begin
              state_q <= BYZERO;
            end else if (earlyOut) begin
              quot_q  <= '0;
              rem_q   <= opdata1_i;
              state_q <= END;
            end else begin
              state_q <= ON;
            end
          end
        end

        BYZERO: begin
          quot_q    <= '0;
          rem_q     <= '0;
          divZero_q <= 1'b1;
          state_q   <= END;
        end

        ON: begin
          if (annul_i) begin
            cnt_q   <= '0;
            state_q <= FREE;
          end else if (cnt_q == CNT_W'(WIDTH)) begin
            quot_q  <= quotFix_d;
            rem_q   <= remFix_d;
            cnt_q   <= '0;
            state_q <= END;
          end else begin
            quot_q <= quotStep_d;
            rem_q  <= remStep_d;
            cnt_q  <= cnt_q + CNT_W'(1);
          end
        end

        END: begin
          // The first END edge always publishes the result. Later edges wait
          // for start_i to drop, so a start held high cannot retrigger.
          if (!ready_q) begin
            result_q <= {rem_q, quot_q};
            ready_q  <= 1'b1;
          end else if (!start_i) begin
            result_q  <= '0;
            ready_q   <= 1'b0;
            divZero_q <= 1'b0;
            state_q   <= FREE;
          end
        end

        default: state_q <= FREE;
      endcase
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign div_zero_o = divZero_q;
  assign busy_o     = (state_q != FREE);

endmodule

// File: tb/tb_divider_iter_param.sv
// ---------------------------------------------------------------------------
// tb_divider_iter_param
//
// Self-checking bench for divider_iter_param at WIDTH=32.
//
// A reference model computes each result with plain integer arithmetic. It
// tracks the expected ready/busy timeline as a phase plus an edge count, and
// a compare process on the falling edge checks the DUT against it every
// cycle. Directed vectors also carry hand-computed results and latencies
// that pin the model.
// ---------------------------------------------------------------------------
module tb_divider_iter_param;

  localparam int W = 32;

`ifdef DIV_EARLY_OUT_EN
  localparam int SMALL_LAT = 1;
`else
  localparam int SMALL_LAT = 34;
`endif

  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_DONE = 2;

  logic           clk;
  logic           rst;
  logic           signedIn;
  logic [W-1:0]   opdata1;
  logic [W-1:0]   opdata2;
  logic           startIn;
  logic           annulIn;
  logic [2*W-1:0] resultOut;
  logic           readyOut;
  logic           busyOut;
  logic           divZeroOut;

  int checks = 0;
  int errors = 0;

  int          mPhase;
  int          mEdges;
  int          mLat;
  logic        mCancellable;
  logic [63:0] mExp;
  logic        mDz;

  divider_iter_param #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .signed_i  (signedIn),
    .opdata1_i (opdata1),
    .opdata2_i (opdata2),
    .start_i   (startIn),
    .annul_i   (annulIn),
    .result_o  (resultOut),
    .ready_o   (readyOut),
    .busy_o    (busyOut),
    .div_zero_o(divZeroOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value against its expectation and tally the outcome.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Expected {remainder, quotient} from integer arithmetic.
  // Signed division truncates toward zero, and the remainder takes the sign
  // of the dividend. The signed overflow case is spelled out explicitly.
  function automatic logic [63:0] modelResult(input logic sgn, input logic [31:0] a,
                                              input logic [31:0] b);
    int sa;
    int sb;
    if (b == 32'd0) return 64'd0;
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = a;
    sb = b;
    return {32'(sa % sb), 32'(sa / sb)};
  endfunction

  // Edges from acceptance until ready_o is seen high.
  function automatic int modelLatency(input logic sgn, input logic [31:0] a,
                                      input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    logic [31:0] magA;
    logic [31:0] magB;
`endif
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
    magA = (sgn && a[31]) ? -a : a;
    magB = (sgn && b[31]) ? -b : b;
    if (magA < magB) return 1;
`else
    if (sgn) return 34;
`endif
    return 34;
  endfunction

  // Reference timeline. A normal division may be cancelled on edges
  // E1..E33, which are the edges that leave the iterating state.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mPhase <= P_IDLE;
      mEdges <= 0;
    end else begin
      case (mPhase)
        P_IDLE: begin
          if (startIn && !annulIn) begin
            mExp         <= modelResult(signedIn, opdata1, opdata2);
            mDz          <= (opdata2 == 32'd0);
            mLat         <= modelLatency(signedIn, opdata1, opdata2);
            mCancellable <= (modelLatency(signedIn, opdata1, opdata2) == 34);
            mEdges       <= 0;
            mPhase       <= P_RUN;
          end
        end
        P_RUN: begin
          if (mCancellable && (mEdges + 1 <= 33) && annulIn) begin
            mPhase <= P_IDLE;
          end else begin
            mEdges <= mEdges + 1;
            if (mEdges + 1 >= mLat) mPhase <= P_DONE;
          end
        end
        default: begin
          if (!startIn) mPhase <= P_IDLE;
        end
      endcase
    end
  end

  // Every-cycle compare against the reference timeline.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("ready", {63'd0, readyOut}, {63'd0, mPhase == P_DONE});
      checkOutput("busy", {63'd0, busyOut}, {63'd0, mPhase != P_IDLE});
      if (mPhase == P_DONE) begin
        checkOutput("result", resultOut, mExp);
        checkOutput("divZero", {63'd0, divZeroOut}, {63'd0, mDz});
      end else if (mPhase == P_IDLE) begin
        checkOutput("idleResult", resultOut, 64'd0);
        checkOutput("idleDivZero", {63'd0, divZeroOut}, 64'd0);
      end
    end
  end

  // Run one division.
  // The operands are scrambled after acceptance. The hand-computed result,
  // latency and flag are checked, start is held for holdCycles, and then the
  // return to idle is verified.
  task automatic applyStimulus(input string name, input logic sgn, input logic [31:0] a,
                               input logic [31:0] b, input int holdCycles,
                               input logic [63:0] expRes, input int expLat,
                               input logic expDz);
    int n;
    @(negedge clk);
    signedIn = sgn;
    opdata1  = a;
    opdata2  = b;
    startIn  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    signedIn = ~sgn;
    opdata1  = ~a;
    opdata2  = b ^ 32'h5A5A_A5A5;
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      #1;
      if (readyOut) break;
    end
    if (!readyOut) begin
      checkOutput({name, "/timeout"}, 64'd0, 64'd1);
    end else begin
      checkOutput({name, "/latency"}, 64'(n), 64'(expLat));
      checkOutput({name, "/result"}, resultOut, expRes);
      checkOutput({name, "/divZero"}, {63'd0, divZeroOut}, {63'd0, expDz});
    end
    repeat (holdCycles) @(negedge clk);
    @(negedge clk);
    startIn = 1'b0;
    @(posedge clk);
    #1;
    checkOutput({name, "/releaseReady"}, {63'd0, readyOut}, 64'd0);
    checkOutput({name, "/releaseBusy"}, {63'd0, busyOut}, 64'd0);
    checkOutput({name, "/releaseResult"}, resultOut, 64'd0);
  endtask

  initial begin
    rst      = 1'b0;
    signedIn = 1'b0;
    opdata1  = '0;
    opdata2  = '0;
    startIn  = 1'b0;
    annulIn  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetReady", {63'd0, readyOut}, 64'd0);
    checkOutput("resetBusy", {63'd0, busyOut}, 64'd0);
    checkOutput("resetResult", resultOut, 64'd0);
    checkOutput("resetDivZero", {63'd0, divZeroOut}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    applyStimulus("u100/7", 1'b0, 32'd100, 32'd7, 3, {32'h2, 32'hE}, 34, 1'b0);
    applyStimulus("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0,
                  {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34, 1'b0);
    applyStimulus("uFFFFFFF9/2", 1'b0, 32'hFFFF_FFF9, 32'd2, 0,
                  {32'h1, 32'h7FFF_FFFC}, 34, 1'b0);
    applyStimulus("sMin/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0,
                  {32'h0, 32'h8000_0000}, 34, 1'b0);
    applyStimulus("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0,
                  {32'h1, 32'hFFFF_FFFD}, 34, 1'b0);
    applyStimulus("s-100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1,
                  {32'hFFFF_FFFE, 32'h0000_000E}, 34, 1'b0);
    applyStimulus("uMax/65536", 1'b0, 32'hFFFF_FFFF, 32'h0001_0000, 0,
                  {32'h0000_FFFF, 32'h0000_FFFF}, 34, 1'b0);
    applyStimulus("uMax/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 0,
                  {32'h0, 32'hFFFF_FFFF}, 34, 1'b0);
    applyStimulus("div0", 1'b0, 32'd1234, 32'd0, 2, 64'd0, 2, 1'b1);

    // Cancel an iterating division right after E5; it must be idle at E6.
    @(negedge clk);
    signedIn = 1'b0;
    opdata1  = 32'd1000;
    opdata2  = 32'd3;
    startIn  = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    annulIn = 1'b1;
    startIn = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("annulBusy", {63'd0, busyOut}, 64'd0);
    checkOutput("annulReady", {63'd0, readyOut}, 64'd0);
    @(negedge clk);
    annulIn = 1'b0;
    applyStimulus("u9/3", 1'b0, 32'd9, 32'd3, 0, {32'h0, 32'h3}, 34, 1'b0);

    applyStimulus("u3/10", 1'b0, 32'd3, 32'd10, 0, {32'h3, 32'h0}, SMALL_LAT, 1'b0);
    applyStimulus("s-3/10", 1'b1, 32'hFFFF_FFFD, 32'd10, 0,
                  {32'hFFFF_FFFD, 32'h0}, SMALL_LAT, 1'b0);

    // Assert reset in the middle of an iterating division.
    @(negedge clk);
    signedIn = 1'b0;
    opdata1  = 32'd500;
    opdata2  = 32'd9;
    startIn  = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("rstMidBusy", {63'd0, busyOut}, 64'd0);
    checkOutput("rstMidReady", {63'd0, readyOut}, 64'd0);
    checkOutput("rstMidResult", resultOut, 64'd0);
    @(negedge clk);
    startIn = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    applyStimulus("u100/7again", 1'b0, 32'd100, 32'd7, 0, {32'h2, 32'hE}, 34, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
